// File: rtl/bip_uart_loader.sv
// -----------------------------------------------------------------------------
// bip_uart_loader
//
// Receive-side companion of the BIP debug UART path. It takes bytes from
// uart_rx and decodes a small command protocol:
//   0x01 LOAD : count byte N, then N words sent low byte first. Each word is
//               written to instruction memory starting at address 0.
//   0x02 RUN  : pulses the CPU reset, then raises the CPU enable.
//   0x03 HALT : drops the CPU enable.
// Any other command byte raises a one-cycle error pulse. If a LOAD stalls
// between bytes for too long, it is abandoned. The words already written stay
// in memory, and an error pulse is raised.
//
// Ports
//   i_clock       : system clock, rising edge
//   i_reset       : synchronous, active-high reset
//   i_rx_data     : received byte, valid while i_rx_done is high
//   i_rx_done     : receiver byte-complete level; one byte per rising edge
//   o_wr_en       : instruction memory write strobe, one cycle per word
//   o_wr_addr     : instruction memory write address (held between writes)
//   o_wr_data     : instruction memory write data (held between writes)
//   o_cpu_enable  : CPU run enable level
//   o_cpu_reset   : one-cycle CPU reset pulse (PC and ACC)
//   o_busy        : high whenever a command is in progress
//   o_load_done   : one-cycle pulse when a LOAD completes normally
//   o_error       : one-cycle pulse on unknown command or timeout
// -----------------------------------------------------------------------------
module bip_uart_loader #(
  parameter int NB_DATA            = 16,
  parameter int NB_BYTE            = 8,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int N_TIMEOUT          = 1000000,
  parameter int NB_TIMEOUT         = 20
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NB_BYTE-1:0]            i_rx_data,
  input  logic                          i_rx_done,
  output logic                          o_wr_en,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_wr_addr,
  output logic [NB_DATA-1:0]            o_wr_data,
  output logic                          o_cpu_enable,
  output logic                          o_cpu_reset,
  output logic                          o_busy,
  output logic                          o_load_done,
  output logic                          o_error
);

  localparam logic [NB_BYTE-1:0]    CMD_LOAD    = NB_BYTE'(8'h01);
  localparam logic [NB_BYTE-1:0]    CMD_RUN     = NB_BYTE'(8'h02);
  localparam logic [NB_BYTE-1:0]    CMD_HALT    = NB_BYTE'(8'h03);
  localparam logic [NB_TIMEOUT-1:0] TIMEOUT_MAX = NB_TIMEOUT'(N_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    GET_COUNT,
    GET_LO,
    GET_HI
  } state_t;

  // State and datapath registers
  state_t                        state_reg,       state_next;
  logic                          rx_done_d_reg;
  logic [NB_BYTE-1:0]            count_reg,       count_next;
  logic [NB_BYTE-1:0]            written_reg,     written_next;
  logic [LOG2_N_INSMEM_ADDR-1:0] ptr_reg,         ptr_next;
  logic [NB_BYTE-1:0]            lo_reg,          lo_next;
  logic [NB_TIMEOUT-1:0]         timeout_reg,     timeout_next;

  // Registered outputs
  logic                          wr_en_reg,       wr_en_next;
  logic [LOG2_N_INSMEM_ADDR-1:0] wr_addr_reg,     wr_addr_next;
  logic [NB_DATA-1:0]            wr_data_reg,     wr_data_next;
  logic                          cpu_enable_reg,  cpu_enable_next;
  logic                          cpu_reset_reg,   cpu_reset_next;
  logic                          load_done_reg,   load_done_next;
  logic                          error_reg,       error_next;

  // Take exactly one byte per rising edge of the receiver's done level, even
  // when the receiver holds done high for several cycles.
  logic byte_accept;
  assign byte_accept = i_rx_done & ~rx_done_d_reg;

  // Number of words written after the current word is committed. The counter
  // never wraps because at most 255 words are written.
  logic [NB_BYTE-1:0] written_inc;
  assign written_inc = written_reg + NB_BYTE'(1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg      <= IDLE;
      rx_done_d_reg  <= 1'b0;
      count_reg      <= '0;
      written_reg    <= '0;
      ptr_reg        <= '0;
      lo_reg         <= '0;
      timeout_reg    <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      cpu_enable_reg <= 1'b0;
      cpu_reset_reg  <= 1'b0;
      load_done_reg  <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rx_done_d_reg  <= i_rx_done;
      count_reg      <= count_next;
      written_reg    <= written_next;
      ptr_reg        <= ptr_next;
      lo_reg         <= lo_next;
      timeout_reg    <= timeout_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      cpu_enable_reg <= cpu_enable_next;
      cpu_reset_reg  <= cpu_reset_next;
      load_done_reg  <= load_done_next;
      error_reg      <= error_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    written_next    = written_reg;
    ptr_next        = ptr_reg;
    lo_next         = lo_reg;
    wr_en_next      = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    cpu_enable_next = cpu_enable_reg;
    cpu_reset_next  = 1'b0;
    load_done_next  = 1'b0;
    error_next      = 1'b0;

    // RUN is a two-step sequence. The CPU reset pulse comes first, and the
    // enable rises in the cycle after it. No byte can be accepted in the
    // cycle after RUN, so nothing here conflicts with the FSM below.
    if (cpu_reset_reg) begin
      cpu_enable_next = 1'b1;
    end

    // The inter-byte timer runs only while a command is in progress.
    if (state_reg == IDLE || byte_accept) begin
      timeout_next = '0;
    end else begin
      timeout_next = timeout_reg + NB_TIMEOUT'(1);
    end

    case (state_reg)
      IDLE: begin
        if (byte_accept) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_next      = GET_COUNT;
              cpu_enable_next = 1'b0;
            end
            CMD_RUN: begin
              cpu_reset_next = 1'b1;
            end
            CMD_HALT: begin
              cpu_enable_next = 1'b0;
            end
            default: begin
              error_next = 1'b1;
            end
          endcase
        end
      end

      GET_COUNT: begin
        if (byte_accept) begin
          count_next   = i_rx_data;
          written_next = '0;
          ptr_next     = '0;
          if (i_rx_data == '0) begin
            state_next     = IDLE;
            load_done_next = 1'b1;
          end else begin
            state_next = GET_LO;
          end
        end
      end

      GET_LO: begin
        if (byte_accept) begin
          lo_next    = i_rx_data;
          state_next = GET_HI;
        end
      end

      GET_HI: begin
        if (byte_accept) begin
          wr_en_next   = 1'b1;
          wr_addr_next = ptr_reg;
          wr_data_next = {i_rx_data, lo_reg};
          // The address wraps silently around the memory size.
          ptr_next     = ptr_reg + LOG2_N_INSMEM_ADDR'(1);
          written_next = written_inc;
          if (written_inc == count_reg) begin
            state_next     = IDLE;
            load_done_next = 1'b1;
          end else begin
            state_next = GET_LO;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Abandon a stalled command. A byte that arrives in the same cycle takes
    // priority, so the command is kept alive. A half-received word is dropped
    // and never written.
    if (state_reg != IDLE && !byte_accept && timeout_reg == TIMEOUT_MAX) begin
      state_next   = IDLE;
      error_next   = 1'b1;
      timeout_next = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_wr_en      = wr_en_reg;
  assign o_wr_addr    = wr_addr_reg;
  assign o_wr_data    = wr_data_reg;
  assign o_cpu_enable = cpu_enable_reg;
  assign o_cpu_reset  = cpu_reset_reg;
  assign o_load_done  = load_done_reg;
  assign o_error      = error_reg;
  assign o_busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_bip_uart_loader.sv
`timescale 1ns/1ps
module tb_bip_uart_loader;

  localparam int A_ADDR = 11;   // full-size instruction memory
  localparam int B_ADDR = 2;    // tiny memory to exercise address wrap
  localparam int NTO    = 50;

  localparam int K_WR      = 0;
  localparam int K_WR_DONE = 1;
  localparam int K_DONE    = 2;
  localparam int K_ERR     = 3;
  localparam int K_CPURST  = 4;

  typedef struct {
    int kind;
    int addr;
    int data;
    int cyc;
  } evt_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;

  logic              a_wr_en, a_cpu_enable, a_cpu_reset, a_busy, a_load_done, a_error;
  logic [A_ADDR-1:0] a_wr_addr;
  logic [15:0]       a_wr_data;
  logic              b_wr_en, b_cpu_enable, b_cpu_reset, b_busy, b_load_done, b_error;
  logic [B_ADDR-1:0] b_wr_addr;
  logic [15:0]       b_wr_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  evt_t got_a[$], got_b[$], exp_a[$], exp_b[$];

  always #5 clock = ~clock;

  bip_uart_loader #(
    .NB_DATA(16), .NB_BYTE(8), .LOG2_N_INSMEM_ADDR(A_ADDR),
    .N_TIMEOUT(NTO), .NB_TIMEOUT(20)
  ) dut_a (
    .i_clock(clock), .i_reset(reset), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_wr_en(a_wr_en), .o_wr_addr(a_wr_addr), .o_wr_data(a_wr_data),
    .o_cpu_enable(a_cpu_enable), .o_cpu_reset(a_cpu_reset), .o_busy(a_busy),
    .o_load_done(a_load_done), .o_error(a_error)
  );

  bip_uart_loader #(
    .NB_DATA(16), .NB_BYTE(8), .LOG2_N_INSMEM_ADDR(B_ADDR),
    .N_TIMEOUT(NTO), .NB_TIMEOUT(20)
  ) dut_b (
    .i_clock(clock), .i_reset(reset), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data),
    .o_cpu_enable(b_cpu_enable), .o_cpu_reset(b_cpu_reset), .o_busy(b_busy),
    .o_load_done(b_load_done), .o_error(b_error)
  );

  // Event monitor: each pulse seen on the outputs is logged with its cycle.
  always @(negedge clock) begin
    cyc++;
    if (a_wr_en)          got_a.push_back('{a_load_done ? K_WR_DONE : K_WR, int'(a_wr_addr), int'(a_wr_data), cyc});
    else if (a_load_done) got_a.push_back('{K_DONE, 0, 0, cyc});
    if (a_error)          got_a.push_back('{K_ERR, 0, 0, cyc});
    if (a_cpu_reset)      got_a.push_back('{K_CPURST, 0, 0, cyc});
    if (b_wr_en)          got_b.push_back('{b_load_done ? K_WR_DONE : K_WR, int'(b_wr_addr), int'(b_wr_data), cyc});
    else if (b_load_done) got_b.push_back('{K_DONE, 0, 0, cyc});
    if (b_error)          got_b.push_back('{K_ERR, 0, 0, cyc});
    if (b_cpu_reset)      got_b.push_back('{K_CPURST, 0, 0, cyc});
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a write of word index i lands at i modulo the memory size.
  task automatic exp_push(input int kind, input int idx, input int data);
    exp_a.push_back('{kind, idx % (1 << A_ADDR), data, 0});
    exp_b.push_back('{kind, idx % (1 << B_ADDR), data, 0});
  endtask

  task automatic cmp_q(input string tag, input evt_t got[$], input evt_t exp[$]);
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      check($sformatf("%s_kind%0d", tag, i), got[i].kind, exp[i].kind);
      check($sformatf("%s_addr%0d", tag, i), got[i].addr, exp[i].addr);
      check($sformatf("%s_data%0d", tag, i), got[i].data, exp[i].data);
    end
  endtask

  task automatic compare_events(input string tag);
    repeat (4) @(negedge clock);
    cmp_q({tag, "_a"}, got_a, exp_a);
    cmp_q({tag, "_b"}, got_b, exp_b);
    $display("txn %-14s a_events=%0d b_events=%0d expected=%0d",
             tag, got_a.size(), got_b.size(), exp_a.size());
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  // Called at a negedge. Done stays high for `hold` cycles and then low for
  // at least one cycle.
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) @(negedge clock);
    rx_done = 1'b0;
    repeat (gap + 1) @(negedge clock);
  endtask

  function automatic int pick_hold(input int fixed);
    return (fixed > 0) ? fixed : int'($urandom_range(1, 3));
  endfunction

  task automatic do_load(input string tag, input logic [15:0] words[$], input int hold);
    int n;
    n = words.size();
    send_byte(8'h01, pick_hold(hold), $urandom_range(0, 3));
    check({tag, "_en_off"}, int'(a_cpu_enable), 0);
    check({tag, "_busy_cnt"}, int'(a_busy), 1);
    send_byte(8'(n), pick_hold(hold), $urandom_range(0, 3));
    if (n == 0) exp_push(K_DONE, 0, 0);
    for (int i = 0; i < n; i++) begin
      send_byte(words[i][7:0], pick_hold(hold), $urandom_range(0, 3));
      send_byte(words[i][15:8], pick_hold(hold), $urandom_range(0, 3));
      exp_push((i == n - 1) ? K_WR_DONE : K_WR, i, int'(words[i]));
    end
    compare_events(tag);
    check({tag, "_busy_end"}, int'(a_busy), 0);
    if (n > 0) begin
      check({tag, "_hold_data"}, int'(a_wr_data), int'(words[n-1]));
      check({tag, "_hold_addr"}, int'(a_wr_addr), (n - 1) % (1 << A_ADDR));
    end
  endtask

  task automatic run_cmd(input string tag);
    rx_data = 8'h02;
    rx_done = 1'b1;
    @(negedge clock);
    check({tag, "_rst_t1"}, int'(a_cpu_reset), 1);
    check({tag, "_en_t1"}, int'(a_cpu_enable), 0);
    rx_done = 1'b0;
    @(negedge clock);
    check({tag, "_rst_t2"}, int'(a_cpu_reset), 0);
    check({tag, "_en_t2"}, int'(a_cpu_enable), 1);
    check({tag, "_en_t2_b"}, int'(b_cpu_enable), 1);
    @(negedge clock);
    exp_push(K_CPURST, 0, 0);
    compare_events(tag);
  endtask

  initial begin
    logic [15:0] words[$];
    int n, delta;

    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_wr_en", int'(a_wr_en), 0);
    check("rst_addr", int'(a_wr_addr), 0);
    check("rst_data", int'(a_wr_data), 0);
    check("rst_en", int'(a_cpu_enable), 0);
    check("rst_busy", int'(a_busy), 0);
    check("rst_err", int'(a_error), 0);
    @(negedge clock);

    // Fixed three-word load
    words = '{16'h1234, 16'h5678, 16'h9ABC};
    do_load("load3", words, 1);

    // A long done level must yield exactly one byte per edge
    words = '{16'h55AA};
    do_load("load1_hold5", words, 5);

    // RUN, HALT, unknown command
    run_cmd("run");
    rx_data = 8'h03; rx_done = 1'b1;
    @(negedge clock);
    check("halt_en", int'(a_cpu_enable), 0);
    rx_done = 1'b0;
    @(negedge clock);
    rx_data = 8'h7F; rx_done = 1'b1;
    @(negedge clock);
    check("bad_err", int'(a_error), 1);
    check("bad_en", int'(a_cpu_enable), 0);
    check("bad_busy", int'(a_busy), 0);
    rx_done = 1'b0;
    @(negedge clock);
    exp_push(K_ERR, 0, 0);
    compare_events("halt_bad");

    // RUN followed by LOAD: the load must drop the enable
    run_cmd("run2");
    words = '{16'hC0DE, 16'hBEEF};
    do_load("load_after_run", words, 0);
    check("en_stays_off", int'(a_cpu_enable), 0);

    // Stall mid-load: one word already written, then a timeout
    send_byte(8'h01, 1, 0);
    send_byte(8'h02, 1, 0);
    send_byte(8'h11, 1, 0);
    send_byte(8'h22, 1, 0);
    exp_push(K_WR, 0, 16'h2211);
    exp_push(K_ERR, 0, 0);
    repeat (60) @(negedge clock);
    delta = (got_a.size() >= 2) ? (got_a[1].cyc - got_a[0].cyc) : -1;
    check("timeout_delay_ok", (delta >= NTO - 1 && delta <= NTO) ? 1 : 0, 1);
    check("timeout_busy", int'(a_busy), 0);
    compare_events("timeout");
    words = '{16'h4321};
    do_load("load_after_to", words, 0);

    // Empty load
    words = '{};
    do_load("load0", words, 0);

    // Five words. The small instance wraps its address. One word carries
    // the RUN/HALT opcodes as plain data.
    words = '{16'h0001, 16'hFFFF, 16'h0302, 16'h8000, 16'h0203};
    do_load("load5_wrap", words, 0);

    // Randomised loads
    for (int r = 0; r < 4; r++) begin
      words = '{};
      n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
      do_load($sformatf("rand_load%0d", r), words, 0);
    end

    // Reset while waiting for a high byte
    run_cmd("run3");
    send_byte(8'h01, 1, 0);
    send_byte(8'h02, 1, 0);
    send_byte(8'h11, 1, 0);
    check("pre_rst_busy", int'(a_busy), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_wr_en", int'(a_wr_en), 0);
    check("mid_rst_addr", int'(a_wr_addr), 0);
    check("mid_rst_data", int'(a_wr_data), 0);
    check("mid_rst_en", int'(a_cpu_enable), 0);
    check("mid_rst_busy", int'(a_busy), 0);
    check("mid_rst_rst", int'(a_cpu_reset), 0);
    check("mid_rst_done", int'(a_load_done), 0);
    check("mid_rst_err", int'(a_error), 0);
    check("mid_rst_b_data", int'(b_wr_data), 0);
    compare_events("mid_reset");
    run_cmd("run_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
